// File: rtl/seg_pkg.sv
// Shared constants and types for 7-segment scan monitors.
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h80;

   localparam logic [3:0] SEL_MIN_LO = 4'b0001;
   localparam logic [3:0] SEL_MIN_HI = 4'b0010;
   localparam logic [3:0] SEL_HR_LO  = 4'b0100;
   localparam logic [3:0] SEL_HR_HI  = 4'b1000;

   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_D0   = 3'd1,
      ST_D1   = 3'd2,
      ST_D2   = 3'd3,
      ST_D3   = 3'd4
   } scan_state_t;

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of a 7-segment pattern (dp in bit 7) back to BCD.
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [7:0] pattern,
   output logic       valid,
   output logic [3:0] bcd
);

   // Exact-match lookup; any other pattern (including a lit dp) is invalid.
   always_comb begin
      valid = 1'b1;
      bcd   = 4'd0;
      case (pattern)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit 7-segment HH:MM bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HUNT | waiting for a min_lo capture to start a frame
// ST_D0   | transient, never entered after reset; falls back to hunt
// ST_D1   | min_lo stored, expecting min_hi
// ST_D2   | min_hi stored, expecting hr_lo
// ST_D3   | hr_lo stored, expecting hr_hi (frame completes on capture)
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int CONFIRM_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seg_in,
   input  logic [3:0] sel_in,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [3:0] hr_lo,
   output logic [3:0] hr_hi,
   output logic       time_valid,
   output logic       upd,
   output logic       seg_err,
   output logic       seq_err
);

   logic [7:0]  seg_s1, seg_s2;
   logic [3:0]  sel_s1, sel_s2, sel_prev;
   logic [7:0]  stab_cnt, stab_next;
   logic        sel_change, sel_illegal, capture;
   logic        dec_valid;
   logic [3:0]  dec_bcd;
   scan_state_t state, state_next;
   logic [3:0]  expected_sel;
   logic [3:0]  dig_min_lo, dig_min_hi, dig_hr_lo;
   logic        ld_min_lo, ld_min_hi, ld_hr_lo;
   logic        frame_done, range_ok, frame_ok;
   logic        seq_set, seg_set;
   logic [15:0] frame_word, out_word, cand;
   logic [3:0]  match_cnt, cnt_after;
   logic        load_out;

   seg7_to_bcd u_dec (
      .pattern (seg_s2),
      .valid   (dec_valid),
      .bcd     (dec_bcd)
   );

   // Two-flop synchronizers; the scan source may be on another clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_s1 <= '0;
         seg_s2 <= '0;
         sel_s1 <= '0;
         sel_s2 <= '0;
      end else begin
         seg_s1 <= seg_in;
         seg_s2 <= seg_s1;
         sel_s1 <= sel_in;
         sel_s2 <= sel_s1;
      end
   end

   assign sel_change  = (sel_s2 != sel_prev);
   assign sel_illegal = sel_change && (sel_s2 != 4'b0000) && !is_onehot4(sel_s2);

   // Dwell counter: cleared on a select change, otherwise counts up and saturates.
   always_comb begin
      if (sel_change)
         stab_next = 8'd0;
      else if (stab_cnt == 8'hFF)
         stab_next = stab_cnt;
      else
         stab_next = stab_cnt + 8'd1;
   end

   // The stab_cnt guard keeps capture to one shot even when SETTLE_CYCLES is 255.
   assign capture = !sel_change && is_onehot4(sel_s2) &&
                    (stab_next == 8'(SETTLE_CYCLES)) && (stab_cnt != 8'(SETTLE_CYCLES));

   // Select history and dwell counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_prev <= '0;
         stab_cnt <= '0;
      end else begin
         sel_prev <= sel_s2;
         stab_cnt <= stab_next;
      end
   end

   // Select the digit position each in-frame state is waiting for.
   always_comb begin
      case (state)
         ST_D1:   expected_sel = SEL_MIN_HI;
         ST_D2:   expected_sel = SEL_HR_LO;
         ST_D3:   expected_sel = SEL_HR_HI;
         default: expected_sel = SEL_MIN_LO;
      endcase
   end

   assign range_ok = (dig_min_hi <= 4'd5) && (dec_bcd <= 4'd2) &&
                     !((dec_bcd == 4'd2) && (dig_hr_lo > 4'd3));

   // Frame sequencing and error classification.
   always_comb begin
      state_next = state;
      ld_min_lo  = 1'b0;
      ld_min_hi  = 1'b0;
      ld_hr_lo   = 1'b0;
      frame_done = 1'b0;
      seq_set    = 1'b0;
      seg_set    = 1'b0;
      if (state == ST_D0)
         state_next = ST_HUNT;
      if (sel_illegal) begin
         seq_set    = 1'b1;
         state_next = ST_HUNT;
      end else if (capture) begin
         if ((state inside {ST_D1, ST_D2, ST_D3}) && (sel_s2 == expected_sel)) begin
            if (!dec_valid) begin
               seg_set    = 1'b1;
               state_next = ST_HUNT;
            end else begin
               case (state)
                  ST_D1: begin
                     ld_min_hi  = 1'b1;
                     state_next = ST_D2;
                  end
                  ST_D2: begin
                     ld_hr_lo   = 1'b1;
                     state_next = ST_D3;
                  end
                  default: begin
                     frame_done = 1'b1;
                     seg_set    = !range_ok;
                     state_next = ST_HUNT;
                  end
               endcase
            end
         end else if (sel_s2 == SEL_MIN_LO) begin
            // A min_lo select always (re)starts a frame.
            if (dec_valid) begin
               ld_min_lo  = 1'b1;
               state_next = ST_D1;
            end else begin
               seg_set    = 1'b1;
               state_next = ST_HUNT;
            end
         end else if (state inside {ST_D1, ST_D2, ST_D3}) begin
            seq_set    = 1'b1;
            state_next = ST_HUNT;
         end
      end
   end

   // FSM state and partial-frame digit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_HUNT;
         dig_min_lo <= '0;
         dig_min_hi <= '0;
         dig_hr_lo  <= '0;
      end else begin
         state <= state_next;
         if (ld_min_lo) dig_min_lo <= dec_bcd;
         if (ld_min_hi) dig_min_hi <= dec_bcd;
         if (ld_hr_lo)  dig_hr_lo  <= dec_bcd;
      end
   end

   assign frame_ok   = frame_done && range_ok;
   assign frame_word = {dec_bcd, dig_hr_lo, dig_min_hi, dig_min_lo};
   assign out_word   = {hr_hi, hr_lo, min_hi, min_lo};

   // Confirmation count the incoming frame would produce.
   always_comb begin
      if (frame_word != cand)
         cnt_after = 4'd1;
      else if (match_cnt >= 4'(CONFIRM_FRAMES))
         cnt_after = match_cnt;
      else
         cnt_after = match_cnt + 4'd1;
   end

   assign load_out = frame_ok && (cnt_after == 4'(CONFIRM_FRAMES)) &&
                     ((frame_word != out_word) || !time_valid);

   // Candidate tracking, confirmed outputs and event pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand       <= '0;
         match_cnt  <= '0;
         min_lo     <= '0;
         min_hi     <= '0;
         hr_lo      <= '0;
         hr_hi      <= '0;
         time_valid <= 1'b0;
         upd        <= 1'b0;
         seg_err    <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         if (frame_ok) begin
            cand      <= frame_word;
            match_cnt <= cnt_after;
         end
         if (load_out) begin
            {hr_hi, hr_lo, min_hi, min_lo} <= frame_word;
            time_valid                     <= 1'b1;
         end
         upd     <= load_out;
         seq_err <= seq_set;
         seg_err <= seg_set && !seq_set;
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: directed scans, queued expected events.
module tb_seg_scan_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] seg_in;
   logic [3:0] sel_in;
   logic [3:0] min_lo, min_hi, hr_lo, hr_hi;
   logic       time_valid, upd, seg_err, seq_err;

   always #5 clk = ~clk;

   seg_scan_decoder #(.SETTLE_CYCLES(4), .CONFIRM_FRAMES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .sel_in     (sel_in),
      .min_lo     (min_lo),
      .min_hi     (min_hi),
      .hr_lo      (hr_lo),
      .hr_hi      (hr_hi),
      .time_valid (time_valid),
      .upd        (upd),
      .seg_err    (seg_err),
      .seq_err    (seq_err)
   );

   typedef struct packed {
      logic [2:0]  flags;   // {upd, seg_err, seq_err}
      logic        tv;
      logic [15:0] t;       // {hr_hi, hr_lo, min_hi, min_lo}
   } ev_t;

   localparam logic [2:0] EV_UPD = 3'b100;
   localparam logic [2:0] EV_SEG = 3'b010;
   localparam logic [2:0] EV_SEQ = 3'b001;

   logic [7:0] pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic expect_ev(input logic [2:0] flags, input logic tv, input logic [15:0] t);
      ev_t e;
      e.flags = flags;
      e.tv    = tv;
      e.t     = t;
      exp_q.push_back(e);
   endtask

   // Stimulus always sits just after a rising edge.
   task automatic dwell(input logic [3:0] sel, input logic [7:0] seg, input int n);
      sel_in = sel;
      seg_in = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame(input int hh, input int hl, input int mh, input int ml);
      dwell(4'b0001, pat[ml], 8);
      dwell(4'b0010, pat[mh], 8);
      dwell(4'b0100, pat[hl], 8);
      dwell(4'b1000, pat[hh], 8);
   endtask

   task automatic drain(input string name);
      dwell(4'b0000, 8'h00, 20);
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: every observed pulse must match the next queued expectation.
   initial begin
      ev_t got, e;
      forever begin
         @(negedge clk);
         if (upd === 1'b1 || seg_err === 1'b1 || seq_err === 1'b1) begin
            got.flags = {upd, seg_err, seq_err};
            got.tv    = time_valid;
            got.t     = {hr_hi, hr_lo, min_hi, min_lo};
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_event: got flags=%b tv=%b time=%h, expected no event",
                        got.flags, got.tv, got.t);
            end else begin
               e = exp_q.pop_front();
               check("event_flags", 32'(got.flags), 32'(e.flags));
               check("event_tv", 32'(got.tv), 32'(e.tv));
               check("event_time", 32'(got.t), 32'(e.t));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      sel_in = 4'b0000;
      seg_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst_time", {hr_hi, hr_lo, min_hi, min_lo}, 0);
      check("rst_tv", time_valid, 0);
      check("rst_pulses", {upd, seg_err, seq_err}, 0);
      rst = 1'b0;

      // 1: clean 12:34 confirms on the second frame, third frame is silent
      expect_ev(EV_UPD, 1'b1, 16'h1234);
      frame(1, 2, 3, 4);
      frame(1, 2, 3, 4);
      frame(1, 2, 3, 4);
      drain("t1_drain");
      check("t1_time", {hr_hi, hr_lo, min_hi, min_lo}, 16'h1234);
      check("t1_tv", time_valid, 1);

      // 2: a changed frame needs its own confirmation
      expect_ev(EV_UPD, 1'b1, 16'h1235);
      frame(1, 2, 3, 4);
      frame(1, 2, 3, 5);
      frame(1, 2, 3, 5);
      drain("t2_drain");
      check("t2_time", {hr_hi, hr_lo, min_hi, min_lo}, 16'h1235);

      // 3: dp-only pattern on min_hi discards the frame
      expect_ev(EV_SEG, 1'b1, 16'h1235);
      dwell(4'b0001, pat[5], 8);
      dwell(4'b0010, 8'h80, 8);
      dwell(4'b0100, pat[2], 8);
      dwell(4'b1000, pat[1], 8);
      drain("t3_drain");
      check("t3_time", {hr_hi, hr_lo, min_hi, min_lo}, 16'h1235);

      // 4: out-of-order select, then recovery
      expect_ev(EV_SEQ, 1'b1, 16'h1235);
      dwell(4'b0001, pat[6], 8);
      dwell(4'b0100, pat[2], 8);
      dwell(4'b1000, pat[1], 8);
      drain("t4a_drain");
      expect_ev(EV_UPD, 1'b1, 16'h1236);
      frame(1, 2, 3, 6);
      frame(1, 2, 3, 6);
      drain("t4b_drain");
      check("t4_time", {hr_hi, hr_lo, min_hi, min_lo}, 16'h1236);

      // 5: out-of-range frames from a fresh reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expect_ev(EV_SEG, 1'b0, 16'h0000);
      expect_ev(EV_SEG, 1'b0, 16'h0000);
      frame(2, 5, 0, 0);
      frame(0, 7, 6, 1);
      drain("t5_drain");
      check("t5_tv", time_valid, 0);
      check("t5_time", {hr_hi, hr_lo, min_hi, min_lo}, 0);

      // 6: reset mid-frame, then resume with the 23:59 boundary
      expect_ev(EV_UPD, 1'b1, 16'h1234);
      frame(1, 2, 3, 4);
      frame(1, 2, 3, 4);
      drain("t6a_drain");
      dwell(4'b0001, pat[4], 8);
      dwell(4'b0010, pat[3], 8);
      dwell(4'b0100, pat[2], 4);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_rst_time", {hr_hi, hr_lo, min_hi, min_lo}, 0);
      check("t6_rst_tv", time_valid, 0);
      check("t6_rst_pulses", {upd, seg_err, seq_err}, 0);
      sel_in = 4'b0000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_ev(EV_UPD, 1'b1, 16'h2359);
      frame(2, 3, 5, 9);
      frame(2, 3, 5, 9);
      drain("t6b_drain");
      check("t6_time", {hr_hi, hr_lo, min_hi, min_lo}, 16'h2359);
      check("t6_tv", time_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
